// File: rtl/ultrasonic_pkg.sv
// ---------------------------------------------------------------------------
// ultrasonic_pkg
// Shared definitions for the ultrasonic ranger block:
//   - state_t      : FSM state encoding (IDLE, TRIG, WAIT_RISE, MEASURE, DONE)
//   - DEF_*        : default timing constants for a 50 MHz system clock
//   - cnt_w()      : bit width needed to hold a counter's maximum value
// ---------------------------------------------------------------------------
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int unsigned CLK_HZ            = 50_000_000;
  localparam int unsigned DEF_TRIG_CYCLES   = CLK_HZ / 100_000;   // 10 us
  localparam int unsigned DEF_PERIOD_CYCLES = CLK_HZ / 1000 * 60; // 60 ms
  localparam int unsigned DEF_ECHO_TIMEOUT  = CLK_HZ / 1000 * 30; // 30 ms
  localparam int unsigned DEF_NEAR_THRESH   = 29_000;             // ~10 cm
  localparam int unsigned DEF_NEAR_HITS     = 3;
  localparam int unsigned DEF_DIST_W        = 20;

  // Bits required to represent values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for signals asynchronous to clk.
// Ports:
//   clk   in        destination clock
//   rst   in        asynchronous active-high reset (flops clear to 0)
//   d     in  [W]   asynchronous input
//   q     out [W]   synchronised output, two clk cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ultrasonic_ranger.sv
// ---------------------------------------------------------------------------
// ultrasonic_ranger
// Drives an HC-SR04-style sensor: periodic trigger pulses, echo pulse width
// timing, and a debounced "object near" flag with hysteresis.
// Ports:
//   clk         in              system clock
//   rst         in              asynchronous active-high reset
//   echo        in              sensor echo, asynchronous to clk
//   trig        out             sensor trigger
//   s0          out [DIST_W]    last echo width in clk cycles, all-ones on timeout
//   meas_valid  out             one-cycle pulse when s0 updates
//   timeout     out             last measurement timed out
//   sens_ult    out             debounced object-near level
//   led1        out             copy of sens_ult
// ---------------------------------------------------------------------------
module ultrasonic_ranger
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES   = DEF_TRIG_CYCLES,
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int unsigned ECHO_TIMEOUT  = DEF_ECHO_TIMEOUT,
  parameter int unsigned NEAR_THRESH   = DEF_NEAR_THRESH,
  parameter int unsigned NEAR_HITS     = DEF_NEAR_HITS,
  parameter int unsigned DIST_W        = DEF_DIST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] s0,
  output logic              meas_valid,
  output logic              timeout,
  output logic              sens_ult,
  output logic              led1
);

  localparam int unsigned TW = cnt_w(TRIG_CYCLES);
  localparam int unsigned PW = cnt_w(PERIOD_CYCLES);
  localparam int unsigned EW = cnt_w(ECHO_TIMEOUT);
  localparam int unsigned HW = cnt_w(NEAR_HITS);

  state_t              state;
  logic                echo_s;
  logic [PW-1:0]       period_cnt;
  logic                start_pending;  // forces the first trigger right after reset
  logic [TW-1:0]       trig_cnt;
  logic [EW-1:0]       wcnt;
  logic [EW-1:0]       width;
  logic                to_flag;
  logic                reported;       // DONE already published, waiting for echo low
  logic [HW-1:0]       hit_cnt;
  logic [DIST_W-1:0]   s0_next;
  logic                near;
  logic                period_expired;

  sync_2ff #(.W(1)) u_echo_sync (
    .clk (clk),
    .rst (rst),
    .d   (echo),
    .q   (echo_s)
  );

  assign period_expired = start_pending || (period_cnt == PW'(PERIOD_CYCLES - 1));
  assign near           = !to_flag && (32'(width) < NEAR_THRESH);
  assign led1           = sens_ult;

  // Width reported on s0: saturated to all-ones if it does not fit DIST_W.
  always_comb begin
    // NOTE: assign a default before any branch so every path drives s0_next
    // and no latch is inferred.
    s0_next = '1;
    if (!to_flag) begin
      if ((32'(width) >> DIST_W) != 0) s0_next = '1;
      else                             s0_next = DIST_W'(width);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      period_cnt    <= '0;
      start_pending <= 1'b1;
      trig_cnt      <= '0;
      wcnt          <= '0;
      width         <= '0;
      to_flag       <= 1'b0;
      reported      <= 1'b0;
      hit_cnt       <= '0;
      trig          <= 1'b0;
      s0            <= '0;
      meas_valid    <= 1'b0;
      timeout       <= 1'b0;
      sens_ult      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      // Free-running period timer, saturating; restarted on each trigger.
      if (period_cnt != PW'(PERIOD_CYCLES - 1)) period_cnt <= period_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (period_expired) begin
            state         <= TRIG;
            trig          <= 1'b1;
            trig_cnt      <= '0;
            period_cnt    <= '0;
            start_pending <= 1'b0;
          end
        end

        TRIG: begin
          if (trig_cnt == TW'(TRIG_CYCLES - 1)) begin
            trig  <= 1'b0;
            wcnt  <= '0;
            state <= WAIT_RISE;
          end else begin
            trig_cnt <= trig_cnt + 1'b1;
          end
        end

        // A line already high on entry is taken as an immediate rise.
        WAIT_RISE: begin
          if (echo_s) begin
            width <= EW'(1);
            state <= MEASURE;
          end else if (wcnt == EW'(ECHO_TIMEOUT - 1)) begin
            wcnt    <= EW'(ECHO_TIMEOUT);
            to_flag <= 1'b1;
            state   <= DONE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        MEASURE: begin
          if (!echo_s) begin
            to_flag <= 1'b0;
            state   <= DONE;
          end else begin
            width <= width + 1'b1;
            if (width == EW'(ECHO_TIMEOUT - 1)) begin
              to_flag <= 1'b1;
              state   <= DONE;
            end
          end
        end

        // Publish once; a stuck-high echo keeps us here until it drops.
        DONE: begin
          if (!reported) begin
            s0         <= s0_next;
            timeout    <= to_flag;
            meas_valid <= 1'b1;
            if (near != sens_ult) begin
              if (32'(hit_cnt) + 1 >= NEAR_HITS) begin
                sens_ult <= !sens_ult;
                hit_cnt  <= '0;
              end else begin
                hit_cnt <= hit_cnt + 1'b1;
              end
            end else begin
              hit_cnt <= '0;
            end
          end
          if (echo_s) begin
            reported <= 1'b1;
          end else begin
            reported <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// ---------------------------------------------------------------------------
// tb_ultrasonic_ranger
// Directed and randomised measurements against a behavioural model of the
// ranger: expected s0/timeout come from the driven echo width, and the near
// flag follows a consecutive-disagreement streak model.
// ---------------------------------------------------------------------------
module tb_ultrasonic_ranger;

  localparam int TRIG_CYCLES   = 10;
  localparam int PERIOD_CYCLES = 2000;
  localparam int ECHO_TIMEOUT  = 1000;
  localparam int NEAR_THRESH   = 300;
  localparam int NEAR_HITS     = 2;
  localparam int DIST_W        = 20;
  localparam logic [31:0] ALL_ONES = 32'h000F_FFFF;

  logic              clk;
  logic              rst;
  logic              echo;
  logic              trig;
  logic [DIST_W-1:0] s0;
  logic              meas_valid;
  logic              timeout;
  logic              sens_ult;
  logic              led1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int prev_rise = -1;

  // Behavioural model of the hysteresis.
  bit m_sens = 1'b0;
  int m_hits = 0;

  ultrasonic_ranger #(
    .TRIG_CYCLES   (TRIG_CYCLES),
    .PERIOD_CYCLES (PERIOD_CYCLES),
    .ECHO_TIMEOUT  (ECHO_TIMEOUT),
    .NEAR_THRESH   (NEAR_THRESH),
    .NEAR_HITS     (NEAR_HITS),
    .DIST_W        (DIST_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .echo       (echo),
    .trig       (trig),
    .s0         (s0),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .sens_ult   (sens_ult),
    .led1       (led1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A measurement of w cycles (0 = no echo at all) updates the near streak.
  function automatic void model_meas(input int w);
    bit is_near;
    is_near = (w > 0) && (w < ECHO_TIMEOUT) && (w < NEAR_THRESH);
    if (is_near != m_sens) begin
      m_hits++;
      if (m_hits == NEAR_HITS) begin
        m_sens = !m_sens;
        m_hits = 0;
      end
    end else begin
      m_hits = 0;
    end
  endfunction

  // Wait for a trigger, check its timing, then drive an echo of w cycles
  // starting gap cycles after trig falls (w = 0: leave echo low).
  task automatic run_meas(input bit first, input int gap, input int w, input string tag);
    int n;
    int hi;
    n = 0;
    while (!trig && n < PERIOD_CYCLES + 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_trig_rise"}, 32'(trig), 32'd1);
    if (first) check({tag, "_trig_first_cycle"}, 32'(n), 32'd1);
    if (prev_rise >= 0) check({tag, "_period"}, 32'(cyc - prev_rise), 32'(PERIOD_CYCLES));
    prev_rise = cyc;
    hi = 0;
    while (trig && hi < 50) begin
      @(negedge clk);
      hi++;
    end
    check({tag, "_trig_len"}, 32'(hi), 32'(TRIG_CYCLES));
    repeat (gap) @(negedge clk);
    if (w > 0) begin
      echo = 1'b1;
      repeat (w) @(negedge clk);
      echo = 1'b0;
    end
    n = 0;
    while (!meas_valid && n < ECHO_TIMEOUT + 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_meas_valid"}, 32'(meas_valid), 32'd1);
    model_meas(w);
    check({tag, "_s0"}, 32'(s0), (w == 0 || w >= ECHO_TIMEOUT) ? ALL_ONES : 32'(w));
    check({tag, "_timeout"}, 32'(timeout), (w == 0 || w >= ECHO_TIMEOUT) ? 32'd1 : 32'd0);
    check({tag, "_sens_ult"}, 32'(sens_ult), 32'(m_sens));
    check({tag, "_led1"}, 32'(led1), 32'(m_sens));
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, 32'(meas_valid), 32'd0);
  endtask

  initial begin
    int n;
    int sel;
    int w;
    int bad_trig;
    int extra_mv;

    rst  = 1'b1;
    echo = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_s0", 32'(s0), 32'd0);
    check("rst_meas_valid", 32'(meas_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_sens_ult", 32'(sens_ult), 32'd0);
    check("rst_led1", 32'(led1), 32'd0);
    rst = 1'b0;

    // No echo: timeouts at the trigger period
    run_meas(1'b1, 0, 0, "to1");
    run_meas(1'b0, 0, 0, "to2");

    // Two near measurements flip sens_ult
    run_meas(1'b0, 50, 200, "near_a");
    run_meas(1'b0, 50, 200, "near_b");

    // An agreeing measurement clears the streak
    run_meas(1'b0, 30, 500, "far_a");
    run_meas(1'b0, 30, 200, "near_c");
    run_meas(1'b0, 30, 500, "far_b");
    run_meas(1'b0, 30, 500, "far_c");

    // Threshold boundary: 300 is far, 299 is near
    run_meas(1'b0, 20, 300, "thr_300a");
    run_meas(1'b0, 20, 300, "thr_300b");
    run_meas(1'b0, 20, 299, "thr_299a");
    run_meas(1'b0, 20, 299, "thr_299b");

    // Randomised widths, gaps and occasional timeouts
    for (int k = 0; k < 10; k++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       w = 299;
        1:       w = 300;
        2:       w = 0;
        default: w = int'($urandom_range(20, 900));
      endcase
      run_meas(1'b0, int'($urandom_range(0, 300)), w, "rand");
    end

    // Leave sens_ult at 1 for the later reset check
    run_meas(1'b0, 10, 100, "pre_a");
    run_meas(1'b0, 10, 100, "pre_b");

    // Echo stuck high for 1500 cycles, running past the trigger period
    n = 0;
    while (!trig && n < PERIOD_CYCLES + 100) begin
      @(negedge clk);
      n++;
    end
    check("stuck_trig_rise", 32'(trig), 32'd1);
    check("stuck_period", 32'(cyc - prev_rise), 32'(PERIOD_CYCLES));
    prev_rise = cyc;
    n = 0;
    while (trig && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (600) @(negedge clk);
    echo = 1'b1;
    n = 0;
    while (!meas_valid && n < ECHO_TIMEOUT + 100) begin
      @(negedge clk);
      n++;
    end
    check("stuck_meas_valid", 32'(meas_valid), 32'd1);
    check("stuck_valid_latency", 32'(n >= ECHO_TIMEOUT && n <= ECHO_TIMEOUT + 5), 32'd1);
    model_meas(0);
    check("stuck_s0", 32'(s0), ALL_ONES);
    check("stuck_timeout", 32'(timeout), 32'd1);
    check("stuck_sens_ult", 32'(sens_ult), 32'(m_sens));
    bad_trig = 0;
    extra_mv = 0;
    for (int i = n; i < 1500; i++) begin
      @(negedge clk);
      if (trig) bad_trig++;
      if (meas_valid) extra_mv++;
    end
    check("stuck_no_trig_while_high", 32'(bad_trig), 32'd0);
    check("stuck_single_valid", 32'(extra_mv), 32'd0);
    echo = 1'b0;
    n = 0;
    while (!trig && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stuck_trig_after_fall", 32'(trig), 32'd1);
    check("stuck_trig_fall_delay", 32'(n >= 2 && n <= 8), 32'd1);
    check("stuck_period_stretched", 32'(cyc - prev_rise > PERIOD_CYCLES), 32'd1);

    // Reset in the middle of a measurement
    n = 0;
    while (trig && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (50) @(negedge clk);
    echo = 1'b1;
    repeat (100) @(negedge clk);
    check("mid_sens_before_rst", 32'(sens_ult), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_trig", 32'(trig), 32'd0);
    check("mid_rst_s0", 32'(s0), 32'd0);
    check("mid_rst_meas_valid", 32'(meas_valid), 32'd0);
    check("mid_rst_timeout", 32'(timeout), 32'd0);
    check("mid_rst_sens_ult", 32'(sens_ult), 32'd0);
    check("mid_rst_led1", 32'(led1), 32'd0);
    echo = 1'b0;
    extra_mv = 0;
    repeat (5) begin
      @(negedge clk);
      if (meas_valid) extra_mv++;
    end
    check("mid_rst_no_valid", 32'(extra_mv), 32'd0);
    rst = 1'b0;
    m_sens = 1'b0;
    m_hits = 0;
    prev_rise = -1;

    run_meas(1'b1, 50, 120, "post_rst_a");
    run_meas(1'b0, 50, 120, "post_rst_b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
